// File: rtl/edge_event_counter_pkg.sv
// Shared types and helpers for the edge event counter and its sync/edge-detect stage.
package edge_event_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SAT  = 2'd2
    } state_t;

    // Saturation value of a WIDTH-bit counter.
    function automatic int max_count(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/edge_detect_sync.sv
// Two-flop sample of din and rising-edge detect; ev is high for one cycle per 0->1 of s1.
module edge_detect_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic ev
);

    logic s1, s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    assign ev = s1 & ~s2;

endmodule

// File: rtl/edge_event_counter.sv
// Counts rising edges of din into a saturating counter with sticky threshold and overflow flags.
module edge_event_counter
    import edge_event_counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             rise,
    output logic             hit,
    output logic             ovf,
    output logic [1:0]       state
);

    localparam int MAX_I = max_count(WIDTH);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("edge_event_counter: WIDTH must be in 2..16");
    end
    if (THRESH < 1 || THRESH > MAX_I) begin : g_bad_thresh
        $error("edge_event_counter: THRESH must be in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_I);
    localparam logic [WIDTH-1:0] THR_V = WIDTH'(THRESH);

    logic             ev;
    logic [WIDTH-1:0] count_nxt, count_inc;
    logic             hit_nxt, ovf_nxt, inc;
    state_t           st_q, st_nxt;

    edge_detect_sync u_sync (
        .clk (clk),
        .rst (rst),
        .din (din),
        .ev  (ev)
    );

    assign count_inc = count + WIDTH'(1);
    assign inc       = ev & en & (count != MAX_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            rise  <= 1'b0;
            hit   <= 1'b0;
            ovf   <= 1'b0;
            st_q  <= IDLE;
        end else begin
            count <= count_nxt;
            rise  <= ev & en;
            hit   <= hit_nxt;
            ovf   <= ovf_nxt;
            st_q  <= st_nxt;
        end
    end

    always_comb begin
        count_nxt = count;
        hit_nxt   = hit;
        ovf_nxt   = ovf;
        st_nxt    = st_q;
        if (clr) begin
            // clear wins; an edge in the same cycle is dropped
            count_nxt = '0;
            hit_nxt   = 1'b0;
            ovf_nxt   = 1'b0;
            st_nxt    = IDLE;
        end else begin
            if (inc) begin
                count_nxt = count_inc;
                if (count_inc == THR_V) hit_nxt = 1'b1;
            end else if (ev & en) begin
                ovf_nxt = 1'b1;
            end
            case (st_q)
                IDLE:    if (inc) st_nxt = (count_inc == MAX_V) ? SAT : RUN;
                RUN:     if (inc && count_inc == MAX_V) st_nxt = SAT;
                SAT:     st_nxt = SAT;
                default: st_nxt = IDLE;
            endcase
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_edge_event_counter.sv
// Directed + random bench for edge_event_counter (WIDTH=4, THRESH=3) against an edge-history model.
module tb_edge_event_counter;
    import edge_event_counter_pkg::*;

    localparam int W   = 4;
    localparam int TH  = 3;
    localparam int MAX = (1 << W) - 1;

    logic         clk, rst, din, en, clr;
    logic [W-1:0] count;
    logic         rise, hit, ovf;
    logic [1:0]   state;

    int compared = 0;
    int mismatched = 0;

    // model: din value seen at each edge, and number of accepted edges since clear
    bit hist[$];
    int n_acc;
    bit exp_rise;

    edge_event_counter #(.WIDTH(W), .THRESH(TH)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .en    (en),
        .clr   (clr),
        .count (count),
        .rise  (rise),
        .hit   (hit),
        .ovf   (ovf),
        .state (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist = {1'b0, 1'b0};
        n_acc = 0;
        exp_rise = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int ec;
        logic [1:0] es;
        ec = (n_acc > MAX) ? MAX : n_acc;
        es = (n_acc == 0) ? IDLE : (n_acc >= MAX) ? SAT : RUN;
        chk({tag, ".count"}, 32'(count), 32'(ec));
        chk({tag, ".rise"},  32'(rise),  32'(exp_rise));
        chk({tag, ".hit"},   32'(hit),   32'(n_acc >= TH));
        chk({tag, ".ovf"},   32'(ovf),   32'(n_acc > MAX));
        chk({tag, ".state"}, 32'(state), 32'(es));
    endtask

    // One clock edge: model consumes the inputs in force at the edge, outputs checked 1ns later.
    task automatic tick(input string tag);
        bit c_din, c_en, c_clr, ev;
        c_din = din; c_en = en; c_clr = clr;
        @(posedge clk);
        ev = hist[$] && !hist[$-1];
        exp_rise = ev && c_en;
        if (c_clr) n_acc = 0;
        else if (ev && c_en) n_acc++;
        hist.push_back(c_din);
        if (hist.size() > 4) void'(hist.pop_front());
        #1;
        check_all(tag);
    endtask

    task automatic pulse(input string tag);
        din = 1'b1; tick(tag);
        din = 1'b0; tick(tag);
    endtask

    initial begin
        rst = 1'b0; din = 1'b0; en = 1'b0; clr = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check_all("reset");
        rst = 1'b0;

        // 1: single rising edge held high
        en = 1'b1;
        tick("t1"); tick("t1");
        din = 1'b1;
        repeat (6) tick("t1");
        chk("t1.count_once", 32'(count), 32'd1);

        // 2: threshold on the third edge, sticky afterwards
        din = 1'b0; clr = 1'b1; tick("t2"); clr = 1'b0;
        repeat (5) pulse("t2");
        tick("t2"); tick("t2");
        chk("t2.count5", 32'(count), 32'd5);
        chk("t2.hit", 32'(hit), 32'd1);

        // 3: saturation and overflow
        clr = 1'b1; tick("t3"); clr = 1'b0;
        repeat (16) pulse("t3");
        tick("t3"); tick("t3");
        chk("t3.sat", 32'(count), 32'(MAX));
        chk("t3.ovf", 32'(ovf), 32'd1);
        chk("t3.state", 32'(state), 32'(SAT));

        // 4: edges with en=0 are discarded
        clr = 1'b1; tick("t4"); clr = 1'b0;
        en = 1'b0;
        repeat (2) pulse("t4");
        tick("t4"); tick("t4");
        en = 1'b1;
        pulse("t4"); tick("t4"); tick("t4");
        chk("t4.count1", 32'(count), 32'd1);

        // 5: clear in the same cycle as an edge
        clr = 1'b1; tick("t5"); clr = 1'b0;
        repeat (7) pulse("t5");
        tick("t5");
        din = 1'b1; tick("t5");
        din = 1'b0; clr = 1'b1; tick("t5"); clr = 1'b0;
        chk("t5.rise", 32'(rise), 32'd1);
        chk("t5.count0", 32'(count), 32'd0);
        chk("t5.state", 32'(state), 32'(IDLE));

        // 6: async reset between edges with an edge already in s1
        repeat (9) pulse("t6");
        din = 1'b1; tick("t6");
        din = 1'b0;
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("t6.async");
        #1 rst = 1'b0;
        repeat (3) tick("t6");
        chk("t6.no_stale", 32'(count), 32'd0);

        // random phase
        for (int i = 0; i < 400; i++) begin
            din = ($urandom_range(0, 2) != 0) ? ~din : din;
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 39) == 0);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/edge_event_counter.md
Name: edge_event_counter

Overview:
Downstream consumer of the single-bit registered output of the dff_comb_one_clock test block. It samples that flop output on the same clock, detects rising edges, and counts them into a saturating counter. It raises a sticky threshold flag and an overflow flag. It gives V2X clock-detection tests a second clocked stage with real state: a pipeline, an FSM and a counter.

Parameters:
WIDTH, 8, counter width in bits; legal range 2..16.
THRESH, 4, count value that sets hit; legal range 1..(2**WIDTH-1). Elaboration fails outside this range.

Ports:
clk  input  1  sole clock; all state is updated on its posedge.
rst  input  1  asynchronous, active-high reset.
din  input  1  event input (the flop output d of the upstream block); synchronous to clk.
en  input  1  count enable.
clr  input  1  synchronous clear of count, hit, ovf and state.
count  output  WIDTH  current event count.
rise  output  1  one-cycle pulse per counted rising edge of din.
hit  output  1  sticky; set when count reaches THRESH.
ovf  output  1  sticky; set on an edge arriving while saturated.
state  output  2  FSM state, encoded per package.

Behaviour:
- Reset (rst=1, asynchronous): s1, s2, count, rise, hit, ovf all 0; state=IDLE. Reset asserted mid-operation overrides everything immediately.
- Sync pipeline: s1 <= din, s2 <= s1 every posedge, independent of en and clr.
- Edge detect: ev = s1 & ~s2 (combinational).
- rise <= ev & en. rise does not depend on clr.
- Latency: din rises before edge E0, so s1=1 after E0. rise and the count update both appear after E1 (2 edges). One pulse per low-to-high transition. din held high gives exactly one event.
- Counter, evaluated at each posedge in this priority order:
  1. clr=1: count<=0, hit<=0, ovf<=0, state<=IDLE. Any ev in the same cycle is dropped.
  2. ev & en and count != 2**WIDTH-1: count<=count+1.
  3. ev & en and count == 2**WIDTH-1: count holds, ovf<=1.
  4. Otherwise: count holds.
- hit <= 1 at the edge where count+1 == THRESH under rule 2. hit stays set until clr; it is never cleared by counting.
- FSM:
  - IDLE (count==0): on an increment, go to RUN. If 2**WIDTH-1 == 1 (not legal), this does not occur.
  - RUN: on an increment to 2**WIDTH-1, go to SAT.
  - SAT: stays in SAT. Further ev & en sets ovf only.
  - clr from any state goes to IDLE.
  - state always agrees with count: IDLE iff count==0; SAT iff count==max.
- en=0: edges are discarded, not deferred. An edge seen while en=0 is never counted later.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package edge_event_counter_pkg:
  - state typedef: IDLE=2'd0, RUN=2'd1, SAT=2'd2; 2'd3 is unused and recovers to IDLE.
  - localparam helper for the maximum count, 2**WIDTH-1.
- Sub-module edge_detect_sync:
  - Holds the s1/s2 pipeline and the ev output.
  - Ports: clk, rst, din, ev.
  - Reused by later clock-detection tests.
- Top level holds the counter, flags and FSM.

Test Plan:
1. Reset, then din 0→1 at cycle 2 and held high, en=1 → rise=1 only in cycle 4; count=1; state=RUN; no further increments while din stays high.
2. WIDTH=4, THRESH=3, three din pulses (1 high / 1 low each), en=1 → hit rises on the same edge count becomes 3; hit stays 1 after two more pulses (count=5).
3. WIDTH=4, 16 pulses → count saturates at 15 after the 15th; 16th pulse sets ovf=1, count stays 15, state=SAT.
4. en=0 for two pulses, then en=1 for one pulse → count=1; rise pulses once.
5. clr asserted in the same cycle ev=1, with count=7 and hit=1 → next cycle count=0, hit=0, ovf=0, state=IDLE; rise=1 that cycle.
6. rst pulsed asynchronously between edges with count=9 → count, flags and rise go to 0 immediately, state=IDLE. After release, a din edge already present in s1 is not counted; s1/s2 restart from 0.
